// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported 4-lane data memory between the CPU
// execute stage (default priority) and a host/debug port. A wait counter
// bounds host starvation and host_lock lets the host hold the memory for
// short bursts. The CPU is stalled on any cycle it requests and loses.
// Optional build macro DMEM_ARB_STATS_EN adds the stall_count and host_beats
// saturating statistics outputs.
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rstd,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [3:0]    cpu_wren,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic [3:0]    host_wren,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wren,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stall_count,
  output logic [15:0]   host_beats
`endif
);

  localparam int LANES = 4;
  localparam int LW    = DW / LANES;
  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  owner_t     owner_reg;
  logic [3:0] wait_cnt_reg;
  logic [3:0] burst_cnt_reg;

  logic force_host;
  logic burst_ok;
  logic host_grant;
  logic cpu_grant;

  // Grant decision: CPU by default, host when alone, starved or continuing a locked burst.
  // Nothing is granted while reset is held so no write can slip through.
  always_comb begin
    force_host = (wait_cnt_reg == MAX_WAIT_C);
    burst_ok   = (owner_reg == OWN_HOST) && host_lock && (burst_cnt_reg < MAX_BURST_C);
    host_grant = rstd && host_req && (!cpu_req || force_host || burst_ok);
    cpu_grant  = rstd && cpu_req && !host_grant;
  end

  assign cpu_stall = rstd && cpu_req && !cpu_grant;
  assign host_ack  = host_grant;
  assign cpu_rdata = mem_rdata;

  // Address mux toward the lanes; idle cycles park the address at 0.
  always_comb begin
    mem_addr = '0;
    if (host_grant) begin
      mem_addr = host_addr;
    end else if (cpu_grant) begin
      mem_addr = cpu_addr;
    end
  end

  // Per-lane data and write-enable steering; an ungranted lane stays read-only.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign mem_wdata[gi*LW +: LW] = host_grant ? host_wdata[gi*LW +: LW] :
                                    cpu_grant  ? cpu_wdata[gi*LW +: LW]  : '0;
    assign mem_wren[gi]           = host_grant ? host_wren[gi] :
                                    cpu_grant  ? cpu_wren[gi]  : 1'b1;
  end

  // Ownership, starvation and burst bookkeeping plus the host read-data register.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      owner_reg     <= OWN_NONE;
      wait_cnt_reg  <= '0;
      burst_cnt_reg <= '0;
      host_rdata    <= '0;
      host_rvalid   <= 1'b0;
    end else begin
      if (host_grant) begin
        owner_reg <= OWN_HOST;
      end else if (cpu_grant) begin
        owner_reg <= OWN_CPU;
      end else begin
        owner_reg <= OWN_NONE;
      end

      if (host_grant || !host_req) begin
        wait_cnt_reg <= '0;
      end else if (wait_cnt_reg < MAX_WAIT_C) begin
        wait_cnt_reg <= wait_cnt_reg + 4'd1;
      end

      if (host_grant) begin
        burst_cnt_reg <= burst_ok ? burst_cnt_reg + 4'd1 : 4'd1;
      end else begin
        burst_cnt_reg <= '0;
      end

      if (host_grant) begin
        host_rdata <= mem_rdata;
      end
      host_rvalid <= host_grant;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating counts of CPU stall cycles and committed host beats.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      stall_count <= '0;
      host_beats  <= '0;
    end else begin
      if (cpu_stall && (stall_count != 16'hffff)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (host_ack && (host_beats != 16'hffff)) begin
        host_beats <= host_beats + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a
// behavioural model (starvation streak, locked run length, reference memory).
// Build with DMEM_ARB_STATS_EN defined to also check the statistics outputs.
module tb_dmem_arbiter;
  localparam int AW        = 8;
  localparam int DW        = 32;
  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;

  logic          clk = 1'b0;
  logic          rstd;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [3:0]    cpu_wren;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          host_req;
  logic          host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [3:0]    host_wren;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wren;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stall_count;
  logic [15:0]   host_beats;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rstd(rstd),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_wren(host_wren), .host_ack(host_ack),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stall_count(stall_count), .host_beats(host_beats)
`endif
  );

  // The four byte lanes: asynchronous read, per-lane active-low write at the clock edge.
  logic [DW-1:0] lanes_mem [0:255] = '{default: '0};
  assign mem_rdata = lanes_mem[mem_addr];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!mem_wren[i]) lanes_mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:255] = '{default: '0};
  int            m_starve;     // consecutive cycles the host has asked and lost
  int            m_run;        // length of the current host run counted under lock rules
  bit            m_prev_host;  // host won the previous cycle
  logic [DW-1:0] m_rdata;
  bit            m_rvalid;
  int            m_stalls;
  int            m_beats;

  int n_checks = 0;
  int n_fail   = 0;
  bit last_ack;
  bit last_stall;

  task automatic model_reset();
    m_starve = 0; m_run = 0; m_prev_host = 0;
    m_rdata = '0; m_rvalid = 0; m_stalls = 0; m_beats = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    bit            hw;
    bit            cw;
    bit            locked_cont;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [3:0]    ew;
    @(negedge clk);
    hw = 0; cw = 0; locked_cont = 0;
    if (!rstd) begin
      model_reset();
    end else begin
      locked_cont = m_prev_host && host_lock && (m_run < MAX_BURST);
      hw = host_req && (!cpu_req || (m_starve >= MAX_WAIT) || locked_cont);
      cw = cpu_req && !hw;
    end
    ea = hw ? host_addr : (cw ? cpu_addr : '0);
    ed = hw ? host_wdata : (cw ? cpu_wdata : '0);
    ew = hw ? host_wren : (cw ? cpu_wren : 4'b1111);

    check("host_ack",    32'(host_ack),    32'(hw));
    check("cpu_stall",   32'(cpu_stall),   32'(rstd && cpu_req && !cw));
    check("mem_addr",    32'(mem_addr),    32'(ea));
    check("mem_wdata",   mem_wdata,        ed);
    check("mem_wren",    32'(mem_wren),    32'(ew));
    check("cpu_rdata",   cpu_rdata,        ref_mem[ea]);
    check("host_rvalid", 32'(host_rvalid), 32'(m_rvalid));
    check("host_rdata",  host_rdata,       m_rdata);
`ifdef DMEM_ARB_STATS_EN
    check("stall_count", 32'(stall_count), 32'(m_stalls));
    check("host_beats",  32'(host_beats),  32'(m_beats));
`endif
    last_ack   = host_ack;
    last_stall = cpu_stall;

    @(posedge clk);
    if (rstd) begin
      if (hw) m_rdata = ref_mem[host_addr];
      m_rvalid    = hw;
      m_run       = hw ? (locked_cont ? m_run + 1 : 1) : 0;
      m_starve    = (host_req && !hw) ? m_starve + 1 : 0;
      m_prev_host = hw;
      if (cpu_req && !cw && m_stalls < 65535) m_stalls++;
      if (hw && m_beats < 65535) m_beats++;
      if (hw || cw) begin
        for (int i = 0; i < 4; i++) begin
          if (!ew[i]) ref_mem[ea][8*i +: 8] = ed[8*i +: 8];
        end
      end
    end
    #1;
  endtask

  initial begin
    model_reset();
    rstd = 1'b0;
    cpu_req = 1'b1; cpu_addr = 8'h01; cpu_wdata = 32'h0badf00d; cpu_wren = 4'b0000;
    host_req = 1'b1; host_lock = 1'b0; host_addr = 8'h02; host_wdata = 32'hcafe0001; host_wren = 4'b0000;

    // Reset held with both requesting: nothing granted, no writes
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("rst_ack",   32'(last_ack),   32'd0);
      check("rst_stall", 32'(last_stall), 32'd0);
    end
    check("rst_nowrite", lanes_mem[8'h01], 32'd0);

    // Full contention, reads only: stall on every 5th cycle
    rstd = 1'b1;
    cpu_wren = 4'b1111; host_wren = 4'b1111;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      check("contention_stall", 32'(last_stall), (k % 5 == 0) ? 32'd1 : 32'd0);
      check("contention_ack",   32'(last_ack),   (k % 5 == 0) ? 32'd1 : 32'd0);
    end
`ifdef DMEM_ARB_STATS_EN
    check("stats_stalls_10", 32'(stall_count), 32'd2);
    check("stats_beats_10",  32'(host_beats),  32'd2);
`endif

    // Host alone: write then read back 0x10
    cpu_req = 1'b0;
    host_addr = 8'h10; host_wdata = 32'hdeadbeef; host_wren = 4'b0000;
    cycle();
    check("host_wr_ack", 32'(last_ack), 32'd1);
    check("host_wr_mem", lanes_mem[8'h10], 32'hdeadbeef);
    host_wren = 4'b1111; host_wdata = 32'h0;
    cycle();
    check("host_rd_ack",    32'(last_ack),    32'd1);
    check("host_rd_rvalid", 32'(host_rvalid), 32'd1);
    check("host_rd_rdata",  host_rdata,       32'hdeadbeef);
    host_req = 1'b0;
    cycle();
    check("host_rvalid_drop", 32'(host_rvalid), 32'd0);

    // Partial CPU write over a host-preloaded word
    host_req = 1'b1; host_addr = 8'h20; host_wdata = 32'h11223344; host_wren = 4'b0000;
    cycle();
    host_req = 1'b0; host_wren = 4'b1111;
    cpu_req = 1'b1; cpu_addr = 8'h20; cpu_wdata = 32'haabbccdd; cpu_wren = 4'b1100;
    cycle();
    check("partial_stall", 32'(last_stall), 32'd0);
    check("partial_mem",   lanes_mem[8'h20], 32'h1122ccdd);

    // Locked burst: first beat uncontended, then 7 more against the CPU, then CPU wins
    cpu_req = 1'b0; cpu_wren = 4'b1111; cpu_addr = 8'h05;
    host_req = 1'b1; host_lock = 1'b1; host_addr = 8'h30; host_wren = 4'b1111;
    cycle();
    check("burst_first_ack", 32'(last_ack), 32'd1);
    cpu_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("burst_ack",   32'(last_ack),   (k <= 7) ? 32'd1 : 32'd0);
      check("burst_stall", 32'(last_stall), (k <= 7) ? 32'd1 : 32'd0);
    end
    host_req = 1'b0; host_lock = 1'b0;
    cycle();

    // Reset in the middle of a locked burst; host keeps presenting its beat
    cpu_req = 1'b0; host_req = 1'b1; host_lock = 1'b1; host_addr = 8'h40;
    host_wdata = 32'h55667788; host_wren = 4'b0000;
    cycle();
    cpu_req = 1'b1; cpu_wren = 4'b1111;
    cycle();
    rstd = 1'b0;
    cycle();
    check("midrst_ack",    32'(last_ack),    32'd0);
    check("midrst_stall",  32'(last_stall),  32'd0);
    check("midrst_rvalid", 32'(host_rvalid), 32'd0);
    rstd = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      check("post_rst_ack", 32'(last_ack), (k == 5) ? 32'd1 : 32'd0);
    end
    host_req = 1'b0; host_lock = 1'b0;
    cycle();

    // Random traffic; host holds its request until acked, occasional reset pulses
    for (int k = 0; k < 600; k++) begin
      rstd      = ($urandom_range(0, 99) != 0);
      cpu_req   = ($urandom_range(0, 2) != 0);
      cpu_addr  = 8'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      cpu_wren  = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
      host_lock = ($urandom_range(0, 3) != 0);
      if (!host_req || last_ack) begin
        host_req   = ($urandom_range(0, 3) != 0);
        host_addr  = 8'($urandom_range(0, 15));
        host_wdata = $urandom;
        host_wren  = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-ported 4-lane data memory (256 words x 32 bits, active-low byte-lane write enables) between the CPU execute stage and a host/debug port. The CPU has default priority. The CPU is stalled for any cycle it loses. A wait counter bounds host starvation, and a lock lets the host run short bursts. The block sits between execute, the data memory lanes and the host bridge; pc/regfile hold when cpu_stall=1.

Parameters:
AW, 8, word address width
DW, 32, data width (4 byte lanes)
MAX_WAIT, 4, host cycles denied before forced host grant (1..15)
MAX_BURST, 8, max consecutive locked host grants (1..15)

Ports:
clk  in  1  clock
rstd  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU memory access this cycle (loads and stores)
cpu_addr  in  AW  CPU word address
cpu_wdata  in  DW  CPU store data
cpu_wren  in  4  CPU lane write enables, active-low (1111 = read)
cpu_stall  out  1  CPU lost arbitration; hold pc, suppress regfile write
cpu_rdata  out  DW  mem_rdata passthrough
host_req  in  1  host access request; held with addr/data until host_ack
host_lock  in  1  request to keep ownership for next beat
host_addr  in  AW  host word address
host_wdata  in  DW  host write data
host_wren  in  4  host lane write enables, active-low
host_ack  out  1  host access commits at this clock edge
host_rdata  out  DW  registered read data of last acked host access
host_rvalid  out  1  one-cycle pulse, cycle after host_ack, host_rdata valid
mem_addr  out  AW  to all four lanes
mem_wdata  out  DW  lane i gets [8i+7:8i]
mem_wren  out  4  active-low lane enables
mem_rdata  in  DW  asynchronous read data from lanes

Behaviour:
- State registers:
  - owner_q {NONE, CPU, HOST}: winner of the previous cycle.
  - wait_cnt (4b), burst_cnt (4b), host_rdata, host_rvalid.
- Reset (rstd=0, async):
  - owner_q=NONE, wait_cnt=0, burst_cnt=0, host_rdata=0, host_rvalid=0.
  - While rstd=0, all grants are forced 0: host_ack=0, cpu_stall=0, mem_wren=1111, mem_addr=0, mem_wdata=0.
  - Reset asserted mid-burst aborts the burst. The uncommitted beat is not acked, and the host re-presents it.
- Per-cycle grant (combinational from registers and current requests):
  - force_host = (wait_cnt == MAX_WAIT).
  - burst_ok = (owner_q == HOST) && host_lock && (burst_cnt < MAX_BURST).
  - host_grant = host_req && (!cpu_req || force_host || burst_ok).
  - cpu_grant = cpu_req && !host_grant.
- Outputs:
  - Muxed mem_addr, mem_wdata and mem_wren come from the granted port. With no grant: mem_wren=1111 and addr/wdata are don't-care (drive 0).
  - cpu_stall = cpu_req && !cpu_grant.
  - host_ack = host_grant, so latency from host_req to ack is 0 cycles when uncontended.
- Clock edge updates:
  - owner_q <= HOST / CPU / NONE according to the grant.
  - wait_cnt:
    - 0 if host_grant or !host_req;
    - otherwise +1, saturating at MAX_WAIT.
  - burst_cnt:
    - if host_grant: burst_ok ? burst_cnt+1 : 1;
    - otherwise 0.
  - host_rdata: on host_grant, host_rdata <= mem_rdata; otherwise hold.
  - host_rvalid <= host_grant.
- Boundaries:
  - Reaching burst_cnt == MAX_BURST ends lock priority. If the CPU is requesting it wins the next cycle, and normal wait counting resumes.
  - A forced grant and an active lock may coincide; the host wins either way.
  - After a forced grant wait_cnt is 0, so the CPU wins at least the next contended cycle unless the lock applies.
- Hazard: lanes read asynchronously, so the same-cycle cpu_rdata is valid only in non-stall cycles.
- Writes are only ever issued for a granted port. A port's write never commits in a stalled or unacked cycle.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds outputs stall_count (16b) and host_beats (16b), both reset to 0.
  - stall_count increments on every cycle with cpu_stall=1.
  - host_beats increments on every host_ack.
  - Both saturate at 16'hffff.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rstd low mid-sequence with host_req=1, cpu_req=1 -> mem_wren=1111, host_ack=0, cpu_stall=0, host_rvalid=0, counters 0.
- Host alone: host_req=1, addr=8'h10, wdata=32'hdeadbeef, wren=0000 -> host_ack same cycle, mem word 0x10=deadbeef. Following read of 0x10 -> host_rvalid next cycle, host_rdata=deadbeef.
- Contention, MAX_WAIT=4: cpu_req and host_req held high continuously -> CPU granted 4 cycles, host forced on cycle 5 (cpu_stall=1 that cycle only), pattern repeats every 5 cycles.
- Burst, MAX_BURST=8: host_lock=1, host_req=1, cpu_req=1 after the first host grant -> 8 consecutive host_acks, then CPU granted; burst_cnt returns to 0.
- Partial write: CPU wren=1100 to addr 8'h20 holding 32'h11223344 with wdata 32'haabbccdd, no host -> word becomes 32'h1122ccdd, cpu_stall=0.
- DMEM_ARB_STATS_EN: 10 cycles of full contention with MAX_WAIT=4 -> stall_count=2, host_beats=2.
